// File: rtl/router_pkg.sv
// Shared parameters and index helpers for the mesh router.
package router_pkg;

  localparam int P      = 5;  // router ports
  localparam int V      = 2;  // VCs per port
  localparam int B      = 4;  // downstream buffer depth per VC
  localparam int PORT_W = 3;  // port index width
  localparam int CNT_W  = 3;  // credit counter width (holds 0..B)
  localparam int VC_W   = 1;  // VC index width

  // Flat bit position of input/output port i, VC v.
  function automatic int flat_idx(input int i, input int v);
    return i * V + v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; pointer moves past the winner only on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] ptr;
  logic [W-1:0] win;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = W'(idx);
      end
    end
  end

  // Advance the pointer to one past the winner when the grant is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && (|gnt)) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Credit-aware, wormhole-preserving separable switch allocator.
module switch_allocator
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P*V-1:0]        req_valid,
  input  logic [P*V*PORT_W-1:0] req_port,
  input  logic [P*V-1:0]        req_tail,
  input  logic [P*V-1:0]        credit_in_array,
  output logic [P*V-1:0]        grant,
  output logic [P*PORT_W-1:0]   xbar_sel,
  output logic [P*VC_W-1:0]     xbar_vc,
  output logic [P-1:0]          wr_out_en_array,
  output logic                  credit_err
);

  logic [CNT_W-1:0]  cnt       [P][V];
  logic              lock_busy [P][V];
  logic [PORT_W-1:0] lock_own  [P][V];

  logic [V-1:0]      elig       [P];
  logic [V-1:0]      s1_gnt     [P];
  logic              cand_valid [P];
  logic [PORT_W-1:0] cand_port  [P];
  logic [VC_W-1:0]   cand_vc    [P];
  logic [P-1:0]      s2_req     [P];
  logic [P-1:0]      s2_gnt     [P];
  logic              in_won     [P];
  logic              out_gnt    [P];
  logic [PORT_W-1:0] out_src    [P];
  logic [VC_W-1:0]   out_vc     [P];
  logic              win_tail   [P];
  logic              cdec       [P][V];
  logic              cinc       [P][V];
  logic [P*V-1:0]    grant_int;

  // Input VC is eligible when its target output VC has credit and is not held by another input.
  always_comb begin
    int fi;
    logic [PORT_W-1:0] p;
    fi = 0;
    p  = '0;
    for (int i = 0; i < P; i++) begin
      elig[i] = '0;
      for (int v = 0; v < V; v++) begin
        fi = flat_idx(i, v);
        p  = req_port[fi*PORT_W +: PORT_W];
        for (int o = 0; o < P; o++) begin
          if (req_valid[fi] && (p == PORT_W'(o)) && (cnt[o][v] != '0) &&
              (!lock_busy[o][v] || (lock_own[o][v] == PORT_W'(i))))
            elig[i][v] = 1'b1;
        end
      end
    end
  end

  // Stage-1 candidate per input: its VC and requested output.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      cand_valid[i] = |s1_gnt[i];
      cand_port[i]  = '0;
      cand_vc[i]    = '0;
      for (int v = 0; v < V; v++) begin
        if (s1_gnt[i][v]) begin
          cand_port[i] = req_port[flat_idx(i, v)*PORT_W +: PORT_W];
          cand_vc[i]   = VC_W'(v);
        end
      end
    end
  end

  // Route each stage-1 candidate to the output arbiter it targets.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++)
        s2_req[o][i] = cand_valid[i] && (cand_port[i] == PORT_W'(o));
    end
  end

  genvar gi;
  for (gi = 0; gi < P; gi++) begin : g_arb
    rr_arbiter #(.N(V)) u_in_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (elig[gi]),
      .advance (in_won[gi]),
      .gnt     (s1_gnt[gi])
    );
    rr_arbiter #(.N(P)) u_out_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (s2_req[gi]),
      .advance (out_gnt[gi]),
      .gnt     (s2_gnt[gi])
    );
  end

  // Decode output winners: source input, VC and whether the winning flit is a tail.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      out_gnt[o] = |s2_gnt[o];
      out_src[o] = '0;
      out_vc[o]  = '0;
      for (int i = 0; i < P; i++) begin
        if (s2_gnt[o][i]) begin
          out_src[o] = PORT_W'(i);
          out_vc[o]  = cand_vc[i];
        end
      end
      win_tail[o] = req_tail[flat_idx(int'(out_src[o]), int'(out_vc[o]))];
    end
  end

  // Final grants: an input pops only if its candidate also won the output.
  always_comb begin
    grant_int = '0;
    for (int i = 0; i < P; i++) begin
      in_won[i] = 1'b0;
      for (int o = 0; o < P; o++)
        if (s2_gnt[o][i]) in_won[i] = 1'b1;
      for (int v = 0; v < V; v++)
        grant_int[flat_idx(i, v)] = in_won[i] && s1_gnt[i][v];
    end
    grant = reset ? grant_int : '0;
  end

  // Per output VC credit consume/return strobes.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int v = 0; v < V; v++) begin
        cdec[o][v] = out_gnt[o] && (out_vc[o] == VC_W'(v));
        cinc[o][v] = credit_in_array[flat_idx(o, v)];
      end
    end
  end

  // Credit counters, wormhole locks and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_err <= 1'b0;
      for (int o = 0; o < P; o++) begin
        for (int v = 0; v < V; v++) begin
          cnt[o][v]       <= CNT_W'(B);
          lock_busy[o][v] <= 1'b0;
          lock_own[o][v]  <= '0;
        end
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        for (int v = 0; v < V; v++) begin
          if (cinc[o][v] && !cdec[o][v]) begin
            if (cnt[o][v] == CNT_W'(B)) credit_err <= 1'b1;
            else                        cnt[o][v] <= cnt[o][v] + 1'b1;
          end else if (cdec[o][v] && !cinc[o][v]) begin
            cnt[o][v] <= cnt[o][v] - 1'b1;
          end
          if (cdec[o][v]) begin
            lock_busy[o][v] <= !win_tail[o];
            lock_own[o][v]  <= out_src[o];
          end
        end
      end
    end
  end

  // Registered crossbar controls; selects hold when an output is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_out_en_array <= '0;
      xbar_sel        <= '0;
      xbar_vc         <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        wr_out_en_array[o] <= out_gnt[o];
        if (out_gnt[o]) begin
          xbar_sel[o*PORT_W +: PORT_W] <= out_src[o];
          xbar_vc[o*VC_W +: VC_W]      <= out_vc[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against a reference model.
module tb_switch_allocator;
  import router_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [P*V-1:0]        req_valid;
  logic [P*V*PORT_W-1:0] req_port;
  logic [P*V-1:0]        req_tail;
  logic [P*V-1:0]        credit_in_array;
  logic [P*V-1:0]        grant;
  logic [P*PORT_W-1:0]   xbar_sel;
  logic [P*VC_W-1:0]     xbar_vc;
  logic [P-1:0]          wr_out_en_array;
  logic                  credit_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: credits, lock owner (-1 = free), round-robin starts.
  int m_cnt [P][V];
  int m_own [P][V];
  int m_p1  [P];
  int m_p2  [P];
  bit m_err;
  int m_win [P];
  int m_wvc [P];
  logic [P*V-1:0] e_grant;
  logic [P-1:0]   e_en;
  int e_sel [P];
  int e_vc  [P];
  logic [P*V-1:0] g_last;

  switch_allocator dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_port        (req_port),
    .req_tail        (req_tail),
    .credit_in_array (credit_in_array),
    .grant           (grant),
    .xbar_sel        (xbar_sel),
    .xbar_vc         (xbar_vc),
    .wr_out_en_array (wr_out_en_array),
    .credit_err      (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int o = 0; o < P; o++) begin
      for (int v = 0; v < V; v++) begin
        m_cnt[o][v] = B;
        m_own[o][v] = -1;
      end
      m_p1[o] = 0; m_p2[o] = 0;
      e_sel[o] = 0; e_vc[o] = 0;
    end
    e_en  = '0;
    m_err = 1'b0;
  endfunction

  function automatic int port_of(input int i, input int v);
    return int'(req_port[(i*V+v)*PORT_W +: PORT_W]);
  endfunction

  function automatic bit can_go(input int i, input int v);
    int p;
    p = port_of(i, v);
    if (!req_valid[i*V+v] || p >= P) return 1'b0;
    if (m_cnt[p][v] == 0) return 1'b0;
    return (m_own[p][v] < 0) || (m_own[p][v] == i);
  endfunction

  // Two-step separable allocation from the allocation rules.
  function automatic void model_eval();
    int cand [P];
    int v, i;
    e_grant = '0;
    for (int n = 0; n < P; n++) begin
      cand[n] = -1;
      for (int k = 0; k < V; k++) begin
        v = (m_p1[n] + k) % V;
        if (cand[n] < 0 && can_go(n, v)) cand[n] = v;
      end
    end
    for (int o = 0; o < P; o++) begin
      m_win[o] = -1; m_wvc[o] = 0;
      for (int k = 0; k < P; k++) begin
        i = (m_p2[o] + k) % P;
        if (m_win[o] < 0 && cand[i] >= 0 && port_of(i, cand[i]) == o) begin
          m_win[o] = i; m_wvc[o] = cand[i];
        end
      end
      if (m_win[o] >= 0) e_grant[m_win[o]*V + m_wvc[o]] = 1'b1;
    end
  endfunction

  function automatic void model_commit();
    bit dec, inc;
    for (int o = 0; o < P; o++) begin
      e_en[o] = (m_win[o] >= 0);
      if (m_win[o] >= 0) begin
        m_p2[o] = (m_win[o] + 1) % P;
        m_p1[m_win[o]] = (m_wvc[o] + 1) % V;
        m_own[o][m_wvc[o]] = req_tail[m_win[o]*V + m_wvc[o]] ? -1 : m_win[o];
        e_sel[o] = m_win[o]; e_vc[o] = m_wvc[o];
      end
      for (int v = 0; v < V; v++) begin
        dec = (m_win[o] >= 0) && (m_wvc[o] == v);
        inc = credit_in_array[o*V+v];
        if (inc && !dec) begin
          if (m_cnt[o][v] == B) m_err = 1'b1;
          else m_cnt[o][v]++;
        end else if (dec && !inc) begin
          m_cnt[o][v]--;
        end
      end
    end
  endfunction

  function automatic logic [P*PORT_W-1:0] exp_sel();
    logic [P*PORT_W-1:0] s;
    for (int o = 0; o < P; o++) s[o*PORT_W +: PORT_W] = PORT_W'(e_sel[o]);
    return s;
  endfunction

  function automatic logic [P-1:0] exp_vc();
    logic [P-1:0] s;
    for (int o = 0; o < P; o++) s[o] = 1'(e_vc[o]);
    return s;
  endfunction

  // One cycle: inputs already driven; check mid-cycle, then advance the model at the edge.
  task automatic step();
    @(negedge clk);
    model_eval();
    check("grant", grant, e_grant);
    check("wr_out_en", wr_out_en_array, e_en);
    check("xbar_sel", xbar_sel, exp_sel());
    check("xbar_vc", xbar_vc, exp_vc());
    check("credit_err", credit_err, m_err);
    g_last = grant;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_wr_en", wr_out_en_array, 0);
    check("rst_sel", xbar_sel, 0);
    check("rst_vc", xbar_vc, 0);
    check("rst_cerr", credit_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic clear();
    req_valid = '0; req_port = '0; req_tail = '0; credit_in_array = '0;
  endtask

  task automatic set_req(input int i, input int v, input int p, input bit tail);
    req_valid[i*V+v] = 1'b1;
    req_port[(i*V+v)*PORT_W +: PORT_W] = PORT_W'(p);
    req_tail[i*V+v] = tail;
  endtask

  initial begin
    int order [3];
    bit tail_done;
    int gaps;
    order[0] = 0; order[1] = 2; order[2] = 8;
    clear();
    g_last = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_grant", grant, 0);
    check("init_wr_en", wr_out_en_array, 0);
    check("init_cerr", credit_err, 0);
    reset = 1'b1;

    // Single-flit packet input 1 VC0 -> port 3.
    set_req(1, 0, 3, 1'b1);
    step();
    check("t1_grant", g_last, 10'h004);
    check("t1_wr_en", wr_out_en_array, 5'b01000);
    check("t1_sel3", xbar_sel[11:9], 1);
    check("t1_vc3", xbar_vc[3], 0);
    clear();
    step();

    // Credit exhaustion on (2,1), refilled by one pulse in cycle 4.
    do_reset();
    clear();
    set_req(0, 1, 2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      credit_in_array = '0;
      credit_in_array[5] = (c == 4);
      step();
      check($sformatf("t2_grant_c%0d", c), g_last[1], (c != 4));
    end

    // Three inputs round-robin on port 2 with credit returned every cycle.
    do_reset();
    clear();
    set_req(0, 0, 2, 1'b1);
    set_req(1, 0, 2, 1'b1);
    set_req(4, 0, 2, 1'b1);
    credit_in_array[4] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("t3_order_c%0d", c), g_last, 32'd1 << order[c % 3]);
    end

    // Wormhole: input 3 VC1 waits for input 0's tail; input 3 VC0 fills gaps.
    do_reset();
    clear();
    set_req(0, 1, 4, 1'b0);
    set_req(3, 1, 4, 1'b1);
    set_req(3, 0, 4, 1'b1);
    tail_done = 1'b0;
    gaps = 0;
    for (int c = 0; c < 10 && !tail_done; c++) begin
      if (c >= 3) req_tail[1] = 1'b1;
      step();
      if (g_last[6]) gaps++;
      if (c > 0) check($sformatf("t4_blocked_c%0d", c), g_last[7], 0);
      if (g_last[1] && req_tail[1]) tail_done = 1'b1;
    end
    check("t4_tail_done", tail_done, 1);
    check("t4_gap_fill", gaps > 0, 1);
    req_valid[1] = 1'b0;
    req_valid[6] = 1'b0;
    step();
    check("t4_unblocked", g_last[7], 1);
    clear();

    // Simultaneous grant and credit on (1,0), then an overflow credit.
    do_reset();
    clear();
    set_req(0, 0, 1, 1'b1);
    credit_in_array[2] = 1'b1;
    step();
    check("t5_grant", g_last[0], 1);
    check("t5_no_err", credit_err, 0);
    clear();
    credit_in_array[2] = 1'b1;
    step();
    check("t5_err", credit_err, 1);
    clear();
    repeat (3) step();
    check("t5_sticky", credit_err, 1);

    // Reset mid-packet clears the lock for a new owner.
    do_reset();
    clear();
    set_req(0, 0, 3, 1'b0);
    step();
    check("t6_head", g_last[0], 1);
    do_reset();
    clear();
    set_req(2, 0, 3, 1'b0);
    step();
    check("t6_new_head", g_last[4], 1);
    clear();
    step();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clear();
      for (int i = 0; i < P; i++) begin
        for (int v = 0; v < V; v++) begin
          if ($urandom_range(0, 2) != 0) begin
            set_req(i, v,
                    ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7)),
                    1'($urandom_range(0, 1)));
          end
          if ((m_cnt[i][v] < B && $urandom_range(0, 2) == 0) || $urandom_range(0, 299) == 0)
            credit_in_array[i*V+v] = 1'b1;
        end
      end
      step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Credit-aware, wormhole-preserving switch allocator for the 5-port, 2-VC mesh router. Each cycle it picks at most one flit per input port and per output port, and pops the winning input-VC buffers. It drives the crossbar selects and `wr_out_en_array`, and tracks downstream buffer credits from `credit_in_array`. It sits between the input-VC buffers and the crossbar/output registers of `router`.

## Interface
- `P`, 5, router ports (index 0..4)
- `V`, 2, VCs per port; downstream VC always equals the input VC index (VC-preserving)
- `B`, 4, downstream buffer depth per VC; initial credit count
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  P*V  input VC (i,v) at bit i*V+v holds a flit
- `req_port`  in  P*V*3  requested output port index per input VC; values ≥P are ignored
- `req_tail`  in  P*V  the flit at the head of (i,v) is a tail flit; head+tail means single-flit packet
- `credit_in_array`  in  P*V  one-cycle pulse: downstream (o,v) freed one slot
- `grant`  out  P*V  combinational; pops input VC (i,v) this cycle
- `xbar_sel`  out  P*3  registered; input port driving output o
- `xbar_vc`  out  P  registered; VC of the flit on output o
- `wr_out_en_array`  out  P  registered; output o carries a valid flit
- `credit_err`  out  1  sticky; a credit arrived while the counter was at B

## Operation
- Credit counter `cnt[o][v]`, 3 bits, reset to B. Grant to (o,v) decrements it; credit pulse increments it; both in one cycle leave it unchanged. A credit pulse at B is dropped and sets `credit_err`.
- Lock `lock[o][v]`: free, or owned by input i. A grant of a non-tail flit sets owner=i. A grant of a tail flit frees the lock.
- Eligible (i,v→o): `req_valid`, `req_port`=o<P, `cnt[o][v]`>0, and lock free or owner==i.
- Stage 1, per input i: V-way round-robin among eligible VCs selects one candidate.
- Stage 2, per output o: P-way round-robin among stage-1 candidates targeting o selects one winner. That winner's `grant` bit is 1.
- Separable, single-iteration allocation. A stage-1 winner that loses stage 2 gets no grant that cycle.
- Each round-robin pointer advances to one past its winner only when a final grant is issued; otherwise it holds.
- There is no FSM beyond the lock bits.
- `grant` is one-hot or zero per input port and per output port.

## Timing
- Cycle t: `grant` is valid combinationally from that cycle's inputs.
- Edge ending t: counters, locks and pointers update.
- Cycle t+1: `wr_out_en_array[o]`=1, with `xbar_sel[o]` and `xbar_vc[o]` describing the cycle-t winner. If o had no grant, `wr_out_en_array[o]`=0 and `xbar_sel`/`xbar_vc` hold their previous values.
- A credit in cycle t is usable for a grant in cycle t+1.
- Reset (`reset`=0) takes effect immediately and holds while low:
  - `grant`=0, `wr_out_en_array`=0, `xbar_sel`=0, `xbar_vc`=0, `credit_err`=0
  - `cnt`=B, all locks free, all pointers 0
- Reset mid-packet discards the lock; upstream must also flush.

## Structure
- Package `router_pkg`: P, V, B, port-index width (3), credit-counter width, and the flat-vector index helper i*V+v.
- One sub-module `rr_arbiter` (parameter N; ports: `req`, `advance`, `gnt`; internal pointer). Instantiate P copies with N=V and P copies with N=P.
- Counters and locks stay in the top level.

## Test plan
- Reset, then `req_valid[2]`=1 (input 1 VC0), `req_port`=3, tail=1 → `grant[2]`=1 in the same cycle. Next cycle: `wr_out_en_array`=5'b01000, `xbar_sel[3]`=1, `xbar_vc[3]`=0, `cnt[3][0]`=3.
- Five single-flit packets from input 0 VC1 to port 2, no credits → grants in cycles 0–3, none in cycle 4. A credit pulse on (2,1) in cycle 4 → grant in cycle 5.
- Inputs 0, 1 and 4, VC0, continuously to port 2, credit returned each cycle → grant order 0,1,4,0,1,4.
- Wormhole:
  - Input 0 VC1 head (non-tail) to port 4 is granted.
  - Input 3 VC1 to port 4 stays blocked until input 0's tail is granted, then is granted the following cycle.
  - Meanwhile input 3 VC0 to port 4 is granted in the gaps.
- Grant and credit on (1,0) in the same cycle → `cnt` unchanged. A credit on an idle counter at 4 → `credit_err`=1 and stays 1.
- `reset` low mid-packet → all outputs 0 in the same cycle. After release, a new head from a different input to the previously locked (o,v) is granted immediately.
